// File: rtl/encoder_bcd_seq_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD encoder.
// bcd_digits() lets integrators size DIGITS for a given binary width.
package encoder_bcd_seq_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // ceil(width * log10(2)) using log10(2) ~= 0.30103.
  function automatic int unsigned bcd_digits(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/encoder_bcd_seq_add3.sv
// One double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/encoder_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD encoder, one input bit per clock, with
// start/ready/valid handshake, overflow detection and leading-zero blanking.
module encoder_bcd_seq
  import encoder_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      BinaryInput,
  output logic                  Ready,
  output logic                  Valid,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  Overflow,
  output logic [DIGITS-1:0]     BlankMask
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [DIGITS-1:0] MaskRst = ~(DIGITS'(1));

  state_e state_q, state_d;

  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] scratch_q, scratch_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                valid_q, valid_d;

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scratch_next;
  logic [WIDTH-1:0]    bin_next;
  logic                shift_out;
  logic [DIGITS-1:0]   mask_next;
  logic                all_zero;
  logic                last_step;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  assign shift_out    = adj[4*DIGITS-1];
  assign scratch_next = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
  assign bin_next     = bin_q << 1;
  assign last_step    = (cnt_q == CntW'(1));

  // Digit i is blank when it and every more-significant digit are zero.
  always_comb begin
    mask_next = '0;
    all_zero  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero     = all_zero & (scratch_next[4*i +: 4] == 4'd0);
      mask_next[i] = all_zero;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = StShift;
      StShift: if (last_step) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bin_d     = bin_q;
    scratch_d = scratch_q;
    ovf_acc_d = ovf_acc_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    mask_d    = mask_q;
    valid_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          bin_d     = BinaryInput;
          scratch_d = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CntW'(WIDTH);
        end
      end
      StShift: begin
        bin_d     = bin_next;
        scratch_d = scratch_next;
        ovf_acc_d = ovf_acc_q | shift_out;
        cnt_d     = cnt_q - CntW'(1);
        if (last_step) begin
          bcd_d   = scratch_next;
          ovf_d   = ovf_acc_q | shift_out;
          mask_d  = mask_next;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bin_q     <= '0;
      scratch_q <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      mask_q    <= MaskRst;
      valid_q   <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      ovf_acc_q <= ovf_acc_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      mask_q    <= mask_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    Ready     = (state_q == StIdle);
    Valid     = valid_q;
    BCD       = bcd_q;
    Overflow  = ovf_q;
    BlankMask = mask_q;
  end

endmodule

// File: tb/tb_encoder_bcd_seq.sv
// Scoreboard bench for encoder_bcd_seq: three configurations (8/3, 8/2, 16/5) share
// one clock; drivers push expected results, a negedge monitor pops and compares.
module tb_encoder_bcd_seq;

  typedef struct {
    logic [39:0] bcd;
    logic        ovf;
    logic [9:0]  mask;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  start_s;
  logic [31:0] bin_s [3];
  logic        rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c, ovf_a, ovf_b, ovf_c;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [19:0] bcd_c;
  logic [2:0]  mask_a;
  logic [1:0]  mask_b;
  logic [4:0]  mask_c;

  wire  [2:0]  ready_s = {rdy_c, rdy_b, rdy_a};
  wire  [2:0]  valid_s = {vld_c, vld_b, vld_a};
  wire  [2:0]  ovf_s   = {ovf_c, ovf_b, ovf_a};
  logic [39:0] bcd_s  [3];
  logic [9:0]  mask_s [3];
  assign bcd_s[0]  = {28'd0, bcd_a};
  assign bcd_s[1]  = {32'd0, bcd_b};
  assign bcd_s[2]  = {20'd0, bcd_c};
  assign mask_s[0] = {7'd0, mask_a};
  assign mask_s[1] = {8'd0, mask_b};
  assign mask_s[2] = {5'd0, mask_c};

  int wid [3] = '{8, 8, 16};
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  encoder_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
    .Clock(clk), .Reset(rst), .Start(start_s[0]), .BinaryInput(bin_s[0][7:0]),
    .Ready(rdy_a), .Valid(vld_a), .BCD(bcd_a), .Overflow(ovf_a), .BlankMask(mask_a)
  );
  encoder_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_b (
    .Clock(clk), .Reset(rst), .Start(start_s[1]), .BinaryInput(bin_s[1][7:0]),
    .Ready(rdy_b), .Valid(vld_b), .BCD(bcd_b), .Overflow(ovf_b), .BlankMask(mask_b)
  );
  encoder_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_c (
    .Clock(clk), .Reset(rst), .Start(start_s[2]), .BinaryInput(bin_s[2][15:0]),
    .Ready(rdy_c), .Valid(vld_c), .BCD(bcd_c), .Overflow(ovf_c), .BlankMask(mask_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Golden decimal conversion, truncated to the low digits.
  function automatic exp_t model(input int unsigned v, input int digits);
    exp_t e;
    int unsigned t = v;
    logic az = 1'b1;
    e.bcd  = '0;
    e.mask = '0;
    e.cyc  = 0;
    for (int d = 0; d < digits; d++) begin
      e.bcd[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    e.ovf = (t != 0);
    for (int i = digits - 1; i >= 1; i--) begin
      az = az & (e.bcd[4*i +: 4] == 4'd0);
      e.mask[i] = az;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic push(input int idx, input logic [39:0] b, input logic o, input logic [9:0] m);
    exp_t e;
    e.bcd = b; e.ovf = o; e.mask = m; e.cyc = cyc + 1 + wid[idx];
    case (idx)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic wait_ready(input int idx, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!ready_s[idx] && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = ready_s[idx];
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout%0d: ready=%b want 1", idx, ready_s[idx]);
    end
  endtask

  task automatic conv(input int idx, input logic [31:0] v, input logic [39:0] b, input logic o,
                      input logic [9:0] m);
    bit ok;
    wait_ready(idx, ok);
    if (!ok) return;
    start_s[idx] = 1'b1;
    bin_s[idx]   = v;
    push(idx, b, o, m);
    @(posedge clk);
    #1;
    start_s[idx] = 1'b0;
    bin_s[idx]   = $urandom;
  endtask

  // Start pulses while busy must be ignored.
  task automatic poke(input int idx);
    repeat (3) begin
      @(negedge clk);
      start_s[idx] = 1'b1;
      bin_s[idx]   = $urandom;
      @(posedge clk);
      #1;
      start_s[idx] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit have;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (valid_s[i]) begin
          have = 1'b0;
          case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
          endcase
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL unexpected_valid%0d: valid=1 at cyc %0d, want none", i, cyc);
          end else if (bcd_s[i] !== e.bcd || ovf_s[i] !== e.ovf || mask_s[i] !== e.mask ||
                       cyc != e.cyc) begin
            errors++;
            $display("FAIL result%0d: got bcd=%h ovf=%b mask=%b cyc=%0d want bcd=%h ovf=%b mask=%b cyc=%0d",
                     i, bcd_s[i], ovf_s[i], mask_s[i], cyc, e.bcd, e.ovf, e.mask, e.cyc);
          end
        end
      end
    end
  end

  logic [31:0] hv [3] = '{32'd12345, 32'd100, 32'd0};
  logic [39:0] hb [3] = '{40'h12345, 40'h00100, 40'h0};
  logic [9:0]  hm [3] = '{10'b00000, 10'b11000, 10'b11110};

  initial begin
    exp_t e;
    bit ok;
    int n;
    rst     = 1'b1;
    start_s = '0;
    for (int i = 0; i < 3; i++) bin_s[i] = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready%0d", i), 40'(ready_s[i]), 40'd1);
      chk($sformatf("rst_valid%0d", i), 40'(valid_s[i]), 40'd0);
      chk($sformatf("rst_bcd%0d", i), bcd_s[i], 40'd0);
      chk($sformatf("rst_ovf%0d", i), 40'(ovf_s[i]), 40'd0);
    end
    chk("rst_mask0", 40'(mask_s[0]), 40'b110);
    chk("rst_mask1", 40'(mask_s[1]), 40'b10);
    chk("rst_mask2", 40'(mask_s[2]), 40'b11110);
    rst = 1'b0;

    conv(0, 255, 40'h255, 1'b0, 10'b000);
    poke(0);
    conv(0, 0,   40'h000, 1'b0, 10'b110);
    conv(0, 7,   40'h007, 1'b0, 10'b110);
    conv(0, 40,  40'h040, 1'b0, 10'b100);

    conv(1, 200, 40'h00, 1'b1, 10'b10);
    conv(1, 99,  40'h99, 1'b0, 10'b00);
    conv(1, 5,   40'h05, 1'b0, 10'b10);

    conv(2, 65535, 40'h65535, 1'b0, 10'b00000);
    poke(2);
    // Start held high: each conversion is taken as soon as Ready returns.
    for (int k = 0; k < 3; k++) begin
      wait_ready(2, ok);
      if (ok) begin
        start_s[2] = 1'b1;
        bin_s[2]   = hv[k];
        push(2, hb[k], 1'b0, hm[k]);
        @(posedge clk);
        #1;
        bin_s[2] = $urandom;
      end
    end
    start_s[2] = 1'b0;

    for (int v = 0; v < 256; v++) begin
      e = model(v, 3);
      conv(0, v, e.bcd, e.ovf, e.mask);
    end

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end

    // Abort mid-conversion: outputs must drop to reset values immediately.
    conv(0, 77, 40'h077, 1'b0, 10'b100);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ready", 40'(rdy_a), 40'd1);
    chk("abort_valid", 40'(vld_a), 40'd0);
    chk("abort_bcd",   40'(bcd_a), 40'd0);
    chk("abort_ovf",   40'(ovf_a), 40'd0);
    chk("abort_mask",  40'(mask_a), 40'b110);
    void'(q0.pop_back());
    @(posedge clk);
    #2;
    rst = 1'b0;
    conv(0, 128, 40'h128, 1'b0, 10'b000);

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      errors++;
      $display("FAIL missing_valid: pending %0d/%0d/%0d want 0/0/0",
               q0.size(), q1.size(), q2.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_bcd_seq.md
Name: encoder_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD encoder. It is the next generation of the team's 8-bit, 3-digit combinational divider-based encoder. It uses an iterative shift-and-add-3 (double-dabble) datapath: one input bit per clock, arbitrary width and digit count, and a start/ready/valid handshake. It adds an overflow flag and leading-zero blanking for the 7-segment display drivers on the DE10 prescaler display path.

Parameters:
WIDTH, 8, binary input width in bits (legal range 1..32).
DIGITS, 3, number of BCD output digits (legal range 1..10); default matches 8-bit full range.

Ports:
Clock  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  request a conversion; sampled only while Ready=1.
BinaryInput  input  WIDTH  value to convert; captured on the accepted Start edge only.
Ready  output  1  high when idle and able to accept Start.
Valid  output  1  one-cycle pulse marking new BCD/Overflow/BlankMask.
BCD  output  4*DIGITS  result; digit i in bits [4i+3:4i], digit 0 = least significant.
Overflow  output  1  result exceeded 10^DIGITS-1; BCD then holds the low DIGITS digits.
BlankMask  output  DIGITS  bit i=1 means digit i is a leading zero; bit 0 is always 0.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-high.
- Reset values:
  - Ready=1, Valid=0, BCD=0, Overflow=0.
  - BlankMask = all ones except bit 0.
  - State IDLE; internal shift register and counter cleared.
- States: IDLE, SHIFT.
- IDLE:
  - Ready=1.
  - On a rising edge with Start=1, capture BinaryInput into the binary shift register, clear the BCD scratch digits and the overflow accumulator, load count=WIDTH, and go to SHIFT.
- SHIFT:
  - Ready=0.
  - Each edge: every scratch digit >=5 gets +3 (4-bit, no carry). Then the concatenation {scratch, binary} shifts left by 1.
  - If the bit shifted out of the top digit is 1, the overflow accumulator is set (sticky for this conversion).
  - count decrements by 1 per edge.
- Completion: the edge on which count reaches 0 (edge WIDTH after the Start edge) does all of the following:
  - registers the final scratch value into BCD, the accumulator into Overflow, and the computed BlankMask;
  - drives Valid=1 for exactly one cycle;
  - returns the block to IDLE (Ready=1 in the same cycle as Valid).
- Latency and throughput:
  - Valid is high in the cycle following edge t0+WIDTH, where t0 is the Start edge.
  - Back-to-back Start is accepted on edge t0+WIDTH+1, giving one conversion per WIDTH+1 cycles.
- Output hold: BCD, Overflow and BlankMask hold their values between Valid pulses. They do not change during SHIFT.
- Start while Ready=0: ignored, with no effect on the conversion in flight. BinaryInput changes during SHIFT are also ignored.
- BlankMask computation:
  - Bit i (i>=1) is 1 iff digits DIGITS-1..i are all zero.
  - Zero input gives BCD=0 and BlankMask = all ones except bit 0.
  - If Overflow=1, BlankMask is still computed from the truncated BCD.
- Reset mid-conversion: the block aborts immediately to reset values with no Valid pulse. Start is honoured on the first edge after Reset deasserts.
- WIDTH=1: a single SHIFT edge; input 1 gives BCD digit0=1.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE/SHIFT;
  - a constant function bcd_digits(width) = ceil(width*log10(2)), used by integrators to size DIGITS;
  - counter width = clog2(WIDTH+1).
- One sub-module, bcd_add3_digit: combinational 4-bit in/out, output in+3 if in>=5, else in. Instantiate it DIGITS times via generate.
- FSM, counter, shift register and output registers stay in encoder_bcd_seq.

Test Plan:
- WIDTH=8, DIGITS=3, BinaryInput=255, Start pulse at t0 -> Valid exactly at t0+8 for one cycle; BCD=12'h255, Overflow=0, BlankMask=3'b000.
- WIDTH=8, DIGITS=3, inputs 0 and 7 -> BCD=12'h000 and 12'h007, both with BlankMask=3'b110; input 40 -> BCD=12'h040, BlankMask=3'b100.
- WIDTH=8, DIGITS=2, input 200 -> BCD=8'h00, Overflow=1; next conversion of 99 -> BCD=8'h99, Overflow=0 (no stickiness across conversions).
- WIDTH=16, DIGITS=5, input 65535 -> Valid at t0+16, BCD=20'h65535. Then Start=1 held continuously -> accepted at every WIDTH+1 edge; Start pulses during Ready=0 cause no extra Valid.
- WIDTH=8, DIGITS=3: assert Reset asynchronously mid-SHIFT (between edges t0+3 and t0+4) -> outputs go to reset values immediately, no Valid. After release, a conversion of 128 -> BCD=12'h128.
- Exhaustive sweep for WIDTH=8, DIGITS=3 -> all 256 values match the golden decimal conversion, with one Valid per accepted Start.
